// File: rtl/s_term_pipe_if.sv
// Southbound-end / northbound-begin wire bundle of the bottom-row terminal tile,
// plus the carry-chain injection bit handed to the tile above.
interface s_term_pipe_if #(
    parameter int W1 = 4,
    parameter int W2 = 8,
    parameter int W4 = 16
);
    logic [W1-1:0] S1END;
    logic [W2-1:0] S2MID;
    logic [W2-1:0] S2END;
    logic [W4-1:0] S4END;
    logic [W4-1:0] SS4END;

    logic [W1-1:0] N1BEG;
    logic [W2-1:0] N2BEG;
    logic [W2-1:0] N2BEGb;
    logic [W4-1:0] N4BEG;
    logic [W4-1:0] NN4BEG;
    logic          Co;

    // Fabric side: drives the southbound ends, observes the looped begins.
    modport master (
        output S1END, S2MID, S2END, S4END, SS4END,
        input  N1BEG, N2BEG, N2BEGb, N4BEG, NN4BEG, Co
    );

    // Terminal tile side.
    modport slave (
        input  S1END, S2MID, S2END, S4END, SS4END,
        output N1BEG, N2BEG, N2BEGb, N4BEG, NN4BEG, Co
    );
endinterface

// File: rtl/s_term_pipe.sv
// South-edge terminal tile: loops southbound wire ends back north with a per-group
// mode (pass / pipelined / zero / freeze) and carry-in, set by a frame-loaded config word.
module s_term_pipe #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int W1              = 4,
    parameter int W2              = 8,
    parameter int W4              = 16,
    parameter int PIPE_DEPTH      = 2,
    parameter int CFG_FRAME       = 0
) (
    input  logic                       UserCLK,
    input  logic                       resetn,
    s_term_pipe_if.slave               wires,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
    output logic                       UserCLKo,
    output logic                       CfgLoaded
);

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_PIPE   = 2'd1,
        MODE_ZERO   = 2'd2,
        MODE_FREEZE = 2'd3
    } mode_e;

    localparam int NUM_GRP = 4;
    localparam int TOTAL_W = W1 + 2 * W2 + 2 * W4;

    // Group g occupies bits [grp_off(g) +: grp_w(g)] of the flattened wire bus.
    function automatic int grp_off(input int g);
        case (g)
            0:       return 0;
            1:       return W1;
            2:       return W1 + 2 * W2;
            default: return W1 + 2 * W2 + W4;
        endcase
    endfunction

    function automatic int grp_w(input int g);
        case (g)
            0:       return W1;
            1:       return 2 * W2;
            default: return W4;
        endcase
    endfunction

    logic [8:0]         cfg_reg;
    logic               s1_reg;
    logic               s2_reg;
    logic               s3_reg;
    logic               cfg_loaded_reg;
    logic               load_next;
    logic [TOTAL_W-1:0] in_bus;
    logic [TOTAL_W-1:0] out_bus;
    logic               unused_frame_bits;

    // Clock and frame strobes pass straight through to the tile above.
    assign FrameStrobe_O = FrameStrobe;
    assign UserCLKo      = UserCLK;

    assign in_bus = {wires.SS4END, wires.S4END, wires.S2END, wires.S2MID, wires.S1END};
    assign {wires.NN4BEG, wires.N4BEG, wires.N2BEGb, wires.N2BEG, wires.N1BEG} = out_bus;

    assign wires.Co  = cfg_reg[8];
    assign CfgLoaded = cfg_loaded_reg;

    assign unused_frame_bits = ^FrameData[FrameBitsPerRow-1:9];

    // The strobe is asynchronous to UserCLK: s1/s2 synchronise it, s3 remembers the
    // previous synchronised level so a strobe held high loads only once.
    assign load_next = s2_reg & ~s3_reg;

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            s1_reg         <= 1'b0;
            s2_reg         <= 1'b0;
            s3_reg         <= 1'b0;
            cfg_reg        <= 9'd0;
            cfg_loaded_reg <= 1'b0;
        end else begin
            s1_reg         <= FrameStrobe[CFG_FRAME];
            s2_reg         <= s1_reg;
            s3_reg         <= s2_reg;
            cfg_loaded_reg <= load_next;
            if (load_next) begin
                cfg_reg <= FrameData[8:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_GRP; gi++) begin : g_grp
            localparam int OFF = grp_off(gi);
            localparam int WID = grp_w(gi);

            mode_e          mode;
            logic [WID-1:0] grp_in;
            logic [WID-1:0] grp_out;
            logic [WID-1:0] stage_reg [PIPE_DEPTH];

            assign mode   = mode_e'(cfg_reg[2*gi +: 2]);
            assign grp_in = in_bus[OFF +: WID];

            // The shift register runs in every mode except freeze, so switching into
            // pipelined mode shows the current tail immediately without a flush.
            always_ff @(posedge UserCLK or negedge resetn) begin
                if (!resetn) begin
                    for (int s = 0; s < PIPE_DEPTH; s++) begin
                        stage_reg[s] <= '0;
                    end
                end else if (mode != MODE_FREEZE) begin
                    stage_reg[0] <= grp_in;
                    for (int s = 1; s < PIPE_DEPTH; s++) begin
                        stage_reg[s] <= stage_reg[s-1];
                    end
                end
            end

            always_comb begin
                grp_out = '0;
                case (mode)
                    MODE_PASS:   grp_out = grp_in;
                    MODE_PIPE:   grp_out = stage_reg[PIPE_DEPTH-1];
                    MODE_ZERO:   grp_out = '0;
                    MODE_FREEZE: grp_out = stage_reg[PIPE_DEPTH-1];
                    default:     grp_out = '0;
                endcase
            end

            assign out_bus[OFF +: WID] = grp_out;
        end
    endgenerate

endmodule

// File: tb/tb_s_term_pipe.sv
// Bench for s_term_pipe: directed scenarios plus randomized traffic checked
// against a queue-based behavioural model of the looped wire groups.
module tb_s_term_pipe;

    localparam int MF = 20;
    localparam int FB = 32;
    localparam int W1 = 4;
    localparam int W2 = 8;
    localparam int W4 = 16;
    localparam int D  = 2;
    localparam int CF = 0;

    logic          clk = 1'b0;
    logic          resetn;
    logic [FB-1:0] frame_data;
    logic [MF-1:0] frame_strobe;
    logic [MF-1:0] frame_strobe_o;
    logic          user_clko;
    logic          cfg_loaded;

    int checks = 0;
    int errors = 0;

    s_term_pipe_if #(.W1(W1), .W2(W2), .W4(W4)) wires ();

    s_term_pipe #(
        .MaxFramesPerCol(MF), .FrameBitsPerRow(FB), .W1(W1), .W2(W2), .W4(W4),
        .PIPE_DEPTH(D), .CFG_FRAME(CF)
    ) u_dut (
        .UserCLK      (clk),
        .resetn       (resetn),
        .wires        (wires.slave),
        .FrameData    (frame_data),
        .FrameStrobe  (frame_strobe),
        .FrameStrobe_O(frame_strobe_o),
        .UserCLKo     (user_clko),
        .CfgLoaded    (cfg_loaded)
    );

    always #5 clk = ~clk;

    // Reference model: cfg word, strobe sample history, and for each group the
    // last D values it accepted (oldest first), which is what a D-deep delay shows.
    logic [8:0]  m_cfg;
    logic        m_loaded;
    bit          smp [3];
    logic [63:0] hist [4][$];

    function automatic logic [63:0] grp_in(input int g);
        case (g)
            0:       return 64'(wires.S1END);
            1:       return 64'({wires.S2END, wires.S2MID});
            2:       return 64'(wires.S4END);
            default: return 64'(wires.SS4END);
        endcase
    endfunction

    function automatic logic [63:0] exp_grp(input int g);
        logic [1:0] md;
        md = m_cfg[2*g +: 2];
        case (md)
            2'd0:    return grp_in(g);
            2'd2:    return 64'd0;
            default: return hist[g][0];
        endcase
    endfunction

    task automatic model_reset();
        m_cfg    = 9'd0;
        m_loaded = 1'b0;
        for (int i = 0; i < 3; i++) smp[i] = 1'b0;
        for (int g = 0; g < 4; g++) begin
            hist[g].delete();
            for (int s = 0; s < D; s++) hist[g].push_back(64'd0);
        end
    endtask

    // Advance one rising edge, update the model, return 1 ns after the edge.
    task automatic step();
        bit load;
        @(posedge clk);
        if (!resetn) begin
            model_reset();
        end else begin
            // A load happens when the strobe was seen high two edges ago and low three ago.
            load = smp[1] && !smp[2];
            for (int g = 0; g < 4; g++) begin
                if (m_cfg[2*g +: 2] != 2'd3) begin
                    hist[g].push_back(grp_in(g));
                    void'(hist[g].pop_front());
                end
            end
            smp[2] = smp[1];
            smp[1] = smp[0];
            smp[0] = frame_strobe[CF];
            m_loaded = load;
            if (load) m_cfg = frame_data[8:0];
        end
        #1;
    endtask

    task automatic load_cfg(input logic [8:0] v);
        frame_data       = FB'(v);
        frame_strobe[CF] = 1'b1;
        repeat (3) step();
        frame_strobe[CF] = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        #1;
        resetn = 1'b0;
        model_reset();
        wires.S1END = 4'hA;
        #1;
        checks++;
        if (wires.N1BEG !== 4'hA) begin
            errors++; $display("FAIL reset_n1beg got %h exp %h", wires.N1BEG, 4'hA);
        end
        checks++;
        if (wires.Co !== 1'b0) begin
            errors++; $display("FAIL reset_co got %b exp 0", wires.Co);
        end
        checks++;
        if (cfg_loaded !== 1'b0) begin
            errors++; $display("FAIL reset_cfgloaded got %b exp 0", cfg_loaded);
        end
        repeat (2) step();
        resetn = 1'b1;
        step();
        checks++;
        if (wires.N1BEG !== 4'hA || wires.Co !== 1'b0) begin
            errors++; $display("FAIL post_reset got n1=%h co=%b exp n1=a co=0", wires.N1BEG, wires.Co);
        end
        $display("test_reset done");
    endtask

    task automatic test_pipe();
        wires.S2MID = 8'h00;
        repeat (3) step();
        load_cfg(9'h004);
        wires.S2MID = 8'h5A;
        wires.S1END = 4'h3;
        #1;
        checks++;
        if (wires.N1BEG !== 4'h3) begin
            errors++; $display("FAIL pipe_g1_comb got %h exp %h", wires.N1BEG, 4'h3);
        end
        checks++;
        if (wires.N2BEG !== 8'h00) begin
            errors++; $display("FAIL pipe_t0 got %h exp %h", wires.N2BEG, 8'h00);
        end
        step();
        checks++;
        if (wires.N2BEG !== 8'h00) begin
            errors++; $display("FAIL pipe_t1 got %h exp %h", wires.N2BEG, 8'h00);
        end
        step();
        checks++;
        if (wires.N2BEG !== 8'h5A) begin
            errors++; $display("FAIL pipe_t2 got %h exp %h", wires.N2BEG, 8'h5A);
        end
        load_cfg(9'h000);
        $display("test_pipe done");
    endtask

    task automatic test_freeze();
        wires.SS4END = 16'h1234;
        load_cfg(9'h0C0);
        wires.SS4END = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (wires.NN4BEG !== 16'h1234) begin
                errors++; $display("FAIL freeze_hold%0d got %h exp %h", i, wires.NN4BEG, 16'h1234);
            end
        end
        load_cfg(9'h000);
        checks++;
        if (wires.NN4BEG !== 16'hFFFF) begin
            errors++; $display("FAIL freeze_release got %h exp %h", wires.NN4BEG, 16'hFFFF);
        end
        $display("test_freeze done");
    endtask

    task automatic test_zero_co();
        wires.S4END      = 16'hBEEF;
        frame_data       = FB'(9'h120);
        frame_strobe[CF] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (cfg_loaded !== 1'b0 || wires.Co !== 1'b0) begin
                errors++; $display("FAIL zero_early%0d got ld=%b co=%b exp ld=0 co=0", i, cfg_loaded, wires.Co);
            end
        end
        step();
        checks++;
        if (cfg_loaded !== 1'b1 || wires.Co !== 1'b1) begin
            errors++; $display("FAIL zero_load got ld=%b co=%b exp ld=1 co=1", cfg_loaded, wires.Co);
        end
        checks++;
        if (wires.N4BEG !== 16'h0000) begin
            errors++; $display("FAIL zero_n4 got %h exp 0000", wires.N4BEG);
        end
        frame_strobe[CF] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wires.S4END = W4'($urandom);
            step();
            checks++;
            if (cfg_loaded !== 1'b0 || wires.Co !== 1'b1 || wires.N4BEG !== 16'h0000) begin
                errors++; $display("FAIL zero_after%0d got ld=%b co=%b n4=%h exp ld=0 co=1 n4=0000",
                                   i, cfg_loaded, wires.Co, wires.N4BEG);
            end
        end
        load_cfg(9'h000);
        $display("test_zero_co done");
    endtask

    task automatic test_held_strobe();
        int pulses;
        pulses           = 0;
        frame_data       = FB'(9'h055);
        frame_strobe[CF] = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 10) frame_strobe[CF] = 1'b0;
            step();
            if (cfg_loaded === 1'b1) pulses++;
            if (i >= 2) frame_data = FB'(32'h100 | $urandom_range(0, 255));
        end
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL held_pulses got %0d exp 1", pulses);
        end
        checks++;
        if (wires.Co !== 1'b0) begin
            errors++; $display("FAIL held_first_value got co=%b exp 0", wires.Co);
        end
        load_cfg(9'h000);
        $display("test_held_strobe done");
    endtask

    task automatic test_reset_abort();
        frame_data       = FB'(9'h1FF);
        frame_strobe[CF] = 1'b1;
        step();
        resetn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (wires.Co !== 1'b0 || cfg_loaded !== 1'b0) begin
            errors++; $display("FAIL abort_now got co=%b ld=%b exp 0 0", wires.Co, cfg_loaded);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (wires.Co !== 1'b0 || cfg_loaded !== 1'b0 || user_clko !== clk || wires.N1BEG !== wires.S1END) begin
                errors++; $display("FAIL abort_hold%0d got co=%b ld=%b clko=%b n1=%h exp co=0 ld=0 clko=%b n1=%h",
                                   i, wires.Co, cfg_loaded, user_clko, wires.N1BEG, clk, wires.S1END);
            end
        end
        @(negedge clk);
        #1;
        frame_strobe = MF'($urandom);
        frame_strobe[CF] = 1'b0;
        #1;
        checks++;
        if (user_clko !== clk || frame_strobe_o !== frame_strobe) begin
            errors++; $display("FAIL abort_passthru got clko=%b fso=%h exp clko=%b fso=%h",
                               user_clko, frame_strobe_o, clk, frame_strobe);
        end
        step();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (wires.Co !== 1'b0 || cfg_loaded !== 1'b0) begin
                errors++; $display("FAIL abort_after%0d got co=%b ld=%b exp 0 0", i, wires.Co, cfg_loaded);
            end
        end
        // Strobe still high when reset is released: loads on the third edge afterwards.
        resetn = 1'b0;
        model_reset();
        frame_data       = FB'(9'h100);
        frame_strobe[CF] = 1'b1;
        step();
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (cfg_loaded !== (i == 2) || wires.Co !== (i == 2)) begin
                errors++; $display("FAIL release_load%0d got ld=%b co=%b exp %b", i, cfg_loaded, wires.Co, i == 2);
            end
        end
        frame_strobe[CF] = 1'b0;
        repeat (2) step();
        load_cfg(9'h000);
        $display("test_reset_abort done");
    endtask

    task automatic test_random();
        logic [63:0] e0, e1, e2, e3;
        logic [MF-1:0] fs;
        bit strobe_on;
        strobe_on = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i % 16 == 0) begin
                frame_data = FB'($urandom);
                strobe_on  = 1'b1;
            end
            if (i % 16 == 4) strobe_on = 1'b0;
            fs               = MF'($urandom);
            fs[CF]           = strobe_on;
            frame_strobe     = fs;
            wires.S1END      = W1'($urandom);
            wires.S2MID      = W2'($urandom);
            wires.S2END      = W2'($urandom);
            wires.S4END      = W4'($urandom);
            wires.SS4END     = W4'($urandom);
            step();
            e0 = exp_grp(0);
            e1 = exp_grp(1);
            e2 = exp_grp(2);
            e3 = exp_grp(3);
            checks++;
            if (wires.N1BEG !== e0[W1-1:0]) begin
                errors++; $display("FAIL rnd%0d_n1 got %h exp %h", i, wires.N1BEG, e0[W1-1:0]);
            end
            checks++;
            if (wires.N2BEG !== e1[W2-1:0] || wires.N2BEGb !== e1[2*W2-1:W2]) begin
                errors++; $display("FAIL rnd%0d_n2 got %h/%h exp %h/%h", i, wires.N2BEG, wires.N2BEGb,
                                   e1[W2-1:0], e1[2*W2-1:W2]);
            end
            checks++;
            if (wires.N4BEG !== e2[W4-1:0]) begin
                errors++; $display("FAIL rnd%0d_n4 got %h exp %h", i, wires.N4BEG, e2[W4-1:0]);
            end
            checks++;
            if (wires.NN4BEG !== e3[W4-1:0]) begin
                errors++; $display("FAIL rnd%0d_nn4 got %h exp %h", i, wires.NN4BEG, e3[W4-1:0]);
            end
            checks++;
            if (wires.Co !== m_cfg[8] || cfg_loaded !== m_loaded) begin
                errors++; $display("FAIL rnd%0d_cfg got co=%b ld=%b exp co=%b ld=%b", i, wires.Co, cfg_loaded,
                                   m_cfg[8], m_loaded);
            end
            checks++;
            if (frame_strobe_o !== frame_strobe) begin
                errors++; $display("FAIL rnd%0d_fso got %h exp %h", i, frame_strobe_o, frame_strobe);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        resetn       = 1'b1;
        frame_data   = '0;
        frame_strobe = '0;
        wires.S1END  = '0;
        wires.S2MID  = '0;
        wires.S2END  = '0;
        wires.S4END  = '0;
        wires.SS4END = '0;
        model_reset();
        test_reset();
        test_pipe();
        test_freeze();
        test_zero_co();
        test_held_strobe();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
